// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with valid/ready handshake, bubble insertion and flush.
// Define ID_EX_SKID_EN to add a skid entry behind the main entry (registered id_ready).
module id_ex_pipe #(
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int REG_W    = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [REG_W-1:0]    id_reg1,
    input  logic [REG_W-1:0]    id_reg2,
    input  logic [ADDR_W-1:0]   id_wd,
    input  logic                id_wreg,
    input  logic [REG_W-1:0]    id_link_addr,
    input  logic                id_in_delayslot,
    input  logic                next_in_delayslot,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [REG_W-1:0]    ex_reg1,
    output logic [REG_W-1:0]    ex_reg2,
    output logic [ADDR_W-1:0]   ex_wd,
    output logic                ex_wreg,
    output logic [REG_W-1:0]    ex_link_addr,
    output logic                ex_in_delayslot,
    output logic                is_in_delayslot_o,
    output logic [1:0]          occupancy
);

    localparam logic [ALUOP_W-1:0]  EXE_NOP_OP    = '0;
    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = '0;
    localparam logic [REG_W-1:0]    ZERO_WORD     = '0;
    localparam logic                WRITE_DISABLE = 1'b0;

    typedef struct packed {
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
        logic [REG_W-1:0]    reg1;
        logic [REG_W-1:0]    reg2;
        logic [ADDR_W-1:0]   wd;
        logic                wreg;
        logic [REG_W-1:0]    link_addr;
        logic                in_ds;
    } pay_t;

    localparam pay_t BUBBLE = '{
        aluop:     EXE_NOP_OP,
        alusel:    EXE_RES_NOP,
        reg1:      ZERO_WORD,
        reg2:      ZERO_WORD,
        wd:        {ADDR_W{1'b0}},
        wreg:      WRITE_DISABLE,
        link_addr: ZERO_WORD,
        in_ds:     1'b0
    };

    pay_t id_pay;
    pay_t main_q, main_d;
    logic main_vld_q, main_vld_d;
    logic dly_q, dly_d;
    logic up, dn;

    assign id_pay = '{
        aluop:     id_aluop,
        alusel:    id_alusel,
        reg1:      id_reg1,
        reg2:      id_reg2,
        wd:        id_wd,
        wreg:      id_wreg,
        link_addr: id_link_addr,
        in_ds:     id_in_delayslot
    };

    assign up = id_valid && id_ready;
    assign dn = main_vld_q && ex_ready;

`ifdef ID_EX_SKID_EN
    pay_t skid_q, skid_d;
    logic skid_vld_q, skid_vld_d;

    // Skid empty is a flop, so id_ready never depends on ex_ready combinationally.
    assign id_ready  = !skid_vld_q;
    assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
`else
    assign id_ready  = !main_vld_q || ex_ready;
    assign occupancy = {1'b0, main_vld_q};
`endif

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        dly_d      = dly_q;
`ifdef ID_EX_SKID_EN
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
`endif
        if (flush) begin
            main_d     = BUBBLE;
            main_vld_d = 1'b0;
            dly_d      = 1'b0;
`ifdef ID_EX_SKID_EN
            skid_d     = BUBBLE;
            skid_vld_d = 1'b0;
`endif
        end else begin
            if (up) begin
                dly_d = next_in_delayslot;
            end
`ifdef ID_EX_SKID_EN
            if (!main_vld_q || dn) begin
                if (skid_vld_q) begin
                    main_d     = skid_q;
                    main_vld_d = 1'b1;
                    skid_d     = BUBBLE;
                    skid_vld_d = 1'b0;
                end else if (up) begin
                    main_d     = id_pay;
                    main_vld_d = 1'b1;
                end else begin
                    main_d     = BUBBLE;
                    main_vld_d = 1'b0;
                end
            end else if (up) begin
                skid_d     = id_pay;
                skid_vld_d = 1'b1;
            end
`else
            if (!main_vld_q || dn) begin
                if (up) begin
                    main_d     = id_pay;
                    main_vld_d = 1'b1;
                end else begin
                    main_d     = BUBBLE;
                    main_vld_d = 1'b0;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q     <= BUBBLE;
            main_vld_q <= 1'b0;
            dly_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            dly_q      <= dly_d;
        end
    end

`ifdef ID_EX_SKID_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_q     <= BUBBLE;
            skid_vld_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
`endif

    assign ex_valid          = main_vld_q;
    assign ex_aluop          = main_q.aluop;
    assign ex_alusel         = main_q.alusel;
    assign ex_reg1           = main_q.reg1;
    assign ex_reg2           = main_q.reg2;
    assign ex_wd             = main_q.wd;
    assign ex_wreg           = main_q.wreg;
    assign ex_link_addr      = main_q.link_addr;
    assign ex_in_delayslot   = main_q.in_ds;
    assign is_in_delayslot_o = dly_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: driver pushes accepted payloads, monitor pops on ex handshake.
// Skid-only scenarios are built when ID_EX_SKID_EN is defined.
module tb_id_ex_pipe;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] link;
        logic        ds;
    } pay_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [7:0]  id_aluop = '0;
    logic [2:0]  id_alusel = '0;
    logic [31:0] id_reg1 = '0;
    logic [31:0] id_reg2 = '0;
    logic [4:0]  id_wd = '0;
    logic        id_wreg = 1'b0;
    logic [31:0] id_link_addr = '0;
    logic        id_in_delayslot = 1'b0;
    logic        next_in_delayslot = 1'b0;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1;
    logic [31:0] ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_link_addr;
    logic        ex_in_delayslot;
    logic        is_in_delayslot_o;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;
    pay_t exp_q[$];
    pay_t vec[8];
    pay_t ex_pay;

    assign ex_pay = {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd,
                     ex_wreg, ex_link_addr, ex_in_delayslot};

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_aluop(id_aluop), .id_alusel(id_alusel),
        .id_reg1(id_reg1), .id_reg2(id_reg2),
        .id_wd(id_wd), .id_wreg(id_wreg),
        .id_link_addr(id_link_addr),
        .id_in_delayslot(id_in_delayslot),
        .next_in_delayslot(next_in_delayslot),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
        .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .ex_link_addr(ex_link_addr),
        .ex_in_delayslot(ex_in_delayslot),
        .is_in_delayslot_o(is_in_delayslot_o),
        .occupancy(occupancy)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input pay_t p, input logic ds);
        {id_aluop, id_alusel, id_reg1, id_reg2, id_wd,
         id_wreg, id_link_addr, id_in_delayslot} = p;
        next_in_delayslot = ds;
    endtask

    // Present p until accepted; the expected response is queued at acceptance.
    task automatic send(input pay_t p, input logic ds);
        bit ok = 0;
        drive(p, ds);
        id_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (id_ready) begin
                exp_q.push_back(p);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        id_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no id_ready expected accept");
        end
    endtask

    logic prev_hold = 1'b0;
    pay_t prev_pay;

    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", ex_valid, 1'b1);
                chk("hold_payload", ex_pay, prev_pay);
            end
            if (ex_valid && ex_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", ex_pay, '0);
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got payload %0h expected none", ex_pay);
                end else begin
                    chk("sb_payload", ex_pay, exp_q.pop_front());
                end
            end else if (!ex_valid) begin
                chk("bubble", ex_pay, '0);
            end
            prev_hold = !flush && ex_valid && !ex_ready;
            prev_pay  = ex_pay;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{8'h21, 3'd1, 32'h12345678, 32'h0, 5'd5, 1'b1, 32'h0, 1'b0};
        vec[1] = '{8'h24, 3'd2, 32'hdeadbeef, 32'h0000ffff, 5'd31, 1'b1, 32'h0, 1'b1};
        vec[2] = '{8'h25, 3'd2, 32'h0, 32'hffffffff, 5'd0, 1'b0, 32'h80000000, 1'b0};
        vec[3] = '{8'h50, 3'd6, 32'hffffffff, 32'h1, 5'd17, 1'b1, 32'hbfc00010, 1'b1};
        vec[4] = '{8'hff, 3'd7, 32'h13579bdf, 32'h2468ace0, 5'd9, 1'b1, 32'h8, 1'b0};
        vec[5] = '{8'h80, 3'd4, 32'ha5a5a5a5, 32'h5a5a5a5a, 5'd1, 1'b0, 32'h1234, 1'b1};
        vec[6] = '{8'h01, 3'd3, 32'h11111111, 32'h22222222, 5'd2, 1'b1, 32'h0, 1'b0};
        vec[7] = '{8'h02, 3'd5, 32'h33333333, 32'h44444444, 5'd3, 1'b1, 32'h0, 1'b0};

        // Reset state
        repeat (3) cyc();
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_occ", occupancy, 2'd0);
        chk("rst_payload", ex_pay, '0);
        chk("rst_ds", is_in_delayslot_o, 1'b0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", id_ready, 1'b1);

        // Single transfer, latency 1
        ex_ready = 1'b1;
        send(vec[0], 1'b1);
        chk("lat_valid", ex_valid, 1'b1);
        chk("lat_reg1", ex_reg1, 32'h12345678);
        chk("lat_wd", ex_wd, 5'd5);
        chk("lat_wreg", ex_wreg, 1'b1);
        chk("ds_set", is_in_delayslot_o, 1'b1);

        // Streaming with simultaneous in/out; delay-slot flag tracks each transfer
        send(vec[1], 1'b0);
        chk("ds_clr", is_in_delayslot_o, 1'b0);
        chk("stream_occ", occupancy, 2'd1);
        send(vec[2], 1'b1);
        chk("ds_set2", is_in_delayslot_o, 1'b1);
        send(vec[3], 1'b0);
        chk("stream_reg2", ex_reg2, 32'h1);
        cyc();
        chk("drain_ds_hold", is_in_delayslot_o, 1'b0);
        cyc();
        chk("drained_valid", ex_valid, 1'b0);

`ifndef ID_EX_SKID_EN
        // Combinational id_ready under backpressure
        ex_ready = 1'b0;
        send(vec[4], 1'b1);
        @(negedge clk);
        chk("bp_valid", ex_valid, 1'b1);
        chk("bp_ready_lo", id_ready, 1'b0);
        chk("bp_occ", occupancy, 2'd1);
        ex_ready = 1'b1;
        #1;
        chk("bp_ready_hi", id_ready, 1'b1);
        cyc();
        cyc();
`else
        // Skid: A on ex, B in skid, C held upstream until drain
        ex_ready = 1'b0;
        send(vec[4], 1'b0);
        send(vec[5], 1'b0);
        chk("skid_occ", occupancy, 2'd2);
        chk("skid_ready", id_ready, 1'b0);
        chk("skid_main", ex_pay, vec[4]);
        fork
            send(vec[6], 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("skid_full_ready", id_ready, 1'b0);
                    chk("skid_full_occ", occupancy, 2'd2);
                end
                @(posedge clk);
                #1;
                ex_ready = 1'b1;
            end
        join
        repeat (3) cyc();
        chk("skid_drained", occupancy, 2'd0);
`endif

        // Flush with held entries and a same-cycle upstream payload
        ex_ready = 1'b0;
        send(vec[5], 1'b1);
`ifdef ID_EX_SKID_EN
        send(vec[6], 1'b1);
        chk("pre_flush_occ", occupancy, 2'd2);
`endif
        drive(vec[7], 1'b1);
        id_valid = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        id_valid = 1'b0;
        exp_q.delete();
        chk("flush_occ", occupancy, 2'd0);
        chk("flush_valid", ex_valid, 1'b0);
        chk("flush_ds", is_in_delayslot_o, 1'b0);
        chk("flush_ready", id_ready, 1'b1);
        ex_ready = 1'b1;
        repeat (4) cyc();

        // Asynchronous reset mid-stream
        ex_ready = 1'b0;
        send(vec[1], 1'b1);
`ifdef ID_EX_SKID_EN
        send(vec[2], 1'b1);
`endif
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", ex_valid, 1'b0);
        chk("arst_aluop", ex_aluop, 8'h00);
        chk("arst_occ", occupancy, 2'd0);
        chk("arst_ds", is_in_delayslot_o, 1'b0);
        exp_q.delete();
        repeat (2) cyc();
        rst = 1'b1;
        #1;
        chk("arst_ready", id_ready, 1'b1);
        ex_ready = 1'b1;
        send(vec[3], 1'b0);
        chk("post_arst_wd", ex_wd, 5'd17);
        repeat (3) cyc();
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter ALUOP_W, default 8, ALU operation code width.
REQ-002 SHALL have parameter ALUSEL_W, default 3, ALU result-select width.
REQ-003 SHALL have parameter REG_W, default 32, operand/link-address width.
REQ-004 SHALL have parameter ADDR_W, default 5, destination register address width.
REQ-005 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: flush  in  1  synchronous pipeline flush.
REQ-008 SHALL have ports: id_valid  in  1; id_ready  out  1; upstream handshake.
REQ-009 SHALL have ports: id_aluop  in  ALUOP_W; id_alusel  in  ALUSEL_W; id_reg1, id_reg2  in  REG_W; id_wd  in  ADDR_W; id_wreg  in  1; id_link_addr  in  REG_W; id_in_delayslot  in  1; next_in_delayslot  in  1.
REQ-010 SHALL have ports: ex_valid  out  1; ex_ready  in  1; downstream handshake.
REQ-011 SHALL have ports: ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_link_addr, ex_in_delayslot  out  widths matching id_* counterparts, all registered.
REQ-012 SHALL have ports: is_in_delayslot_o  out  1  delay-slot flag returned to ID; occupancy  out  2  entries held (0..2).

Function
REQ-013 SHALL transfer a payload upstream only when id_valid && id_ready, downstream only when ex_valid && ex_ready.
REQ-014 SHALL deliver payloads to ex_* in acceptance order; none lost or duplicated.
REQ-015 SHALL drive bubble values whenever ex_valid=0: ex_aluop=EXE_NOP_OP, ex_alusel=EXE_RES_NOP, ex_reg1/ex_reg2/ex_link_addr=ZeroWord, ex_wd=0, ex_wreg=WriteDisable, ex_in_delayslot=0.
REQ-016 SHALL present accepted payload on ex_* one cycle after acceptance when the stage was empty (latency 1).
REQ-017 SHALL hold ex_* and ex_valid stable while ex_valid=1 and ex_ready=0.
REQ-018 SHALL, on upstream transfer, register is_in_delayslot_o <= next_in_delayslot; otherwise hold it.
REQ-019 SHALL treat flush as highest-priority synchronous event: next cycle both entries empty, ex_* at bubble values, ex_valid=0, is_in_delayslot_o=0, occupancy=0; same-cycle upstream payload discarded.
REQ-020 SHALL keep occupancy equal to number of valid entries after every edge.
REQ-021 SHALL, on simultaneous downstream and upstream transfer with one entry held, replace main entry with new payload, occupancy stays 1.

Reset
REQ-022 SHALL, while rst=0, asynchronously force ex_valid=0, ex_* to bubble values, is_in_delayslot_o=0, occupancy=0, skid entry empty.
REQ-023 SHALL let rst dominate flush and any handshake; id_ready=1 in first cycle after rst deasserts.

Configuration
REQ-024 SHALL, with ID_EX_SKID_EN defined, implement main entry plus one skid entry; id_ready is registered and equals !skid_full.
REQ-025 SHALL, with ID_EX_SKID_EN defined, capture an upstream payload into skid when main is full and ex_ready=0; on next downstream transfer main reloads from skid before any new id payload.
REQ-026 SHALL, without ID_EX_SKID_EN, implement main entry only; id_ready = !ex_valid || ex_ready (combinational); occupancy never exceeds 1.

Verification
REQ-027 SHALL cover: rst=0 mid-stream with two entries held -> immediately ex_valid=0, ex_aluop=EXE_NOP_OP, occupancy=0.
REQ-028 SHALL cover: id_valid=1, id_reg1=0x12345678, id_wd=5, id_wreg=1, ex_ready=1 -> next cycle ex_valid=1, ex_reg1=0x12345678, ex_wd=5, ex_wreg=1.
REQ-029 SHALL cover (SKID_EN): ex_ready=0, three back-to-back payloads A,B,C -> A on ex_*, B in skid, occupancy=2, id_ready=0, C held upstream; ex_ready=1 -> A,B,C emerge in order.
REQ-030 SHALL cover: flush=1 with occupancy=2 and id_valid=1 -> next cycle occupancy=0, ex_valid=0, dropped payload never appears.
REQ-031 SHALL cover: transfer with next_in_delayslot=1 -> is_in_delayslot_o=1; following transfer with 0 -> is_in_delayslot_o=0.
REQ-032 SHALL cover (no SKID_EN): ex_ready=0, ex_valid=1 -> id_ready=0 same cycle; ex_ready=1 -> id_ready=1 same cycle.
